cla_pipe_adder: RTL

- Parametrised, pipelined successor to the 4-bit lookahead adder cell.
- Splits WIDTH-bit operands into 4-bit lookahead groups and resolves GPS groups per pipeline stage, one group carry per stage boundary.
- Streams operands with a valid/ready handshake and full back-pressure.
- Sits in the adder/accumulator path of the approximate-multiplier datapaths as a drop-in wide adder.

---
 rtl/cla_pipe_adder.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined WIDTH-bit carry-lookahead adder with valid/ready streaming
// Each stage resolves GPS 4-bit lookahead groups and hands one group carry to the next stage.
// Optional approximate low-bit mode is built when CLA_PIPE_APPROX_EN is defined.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GPS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_PIPE_APPROX_EN
  input  logic [$clog2(WIDTH):0] approx_k,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             g,
  output logic             p,
  output logic             ovf
);

  localparam int NGRP = WIDTH / 4;
  localparam int NSTG = NGRP / GPS;
  localparam int KW   = $clog2(WIDTH) + 1;

  // Stage registers: operands, partial sum, running carry, running word g/p,
  // and the carry into the top bit once the top group has been resolved.
  logic [NSTG-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [NSTG-1:0]            vld_q, vld_d, c_q, c_d, gw_q, gw_d, pw_q, pw_d, cm_q, cm_d;

  // Stage inputs: stage 0 sees the ports, later stages see the previous register.
  logic [NSTG-1:0][WIDTH-1:0] a_s, b_s, sum_s;
  logic [NSTG-1:0]            vld_s, c_s, gw_s, pw_s, cm_s;

  // Per-stage mask of bits that are approximated (a|b, no carry).
  logic [NSTG-1:0][WIDTH-1:0] am_s;

  logic adv;

`ifdef CLA_PIPE_APPROX_EN
  logic [NSTG-1:0][KW-1:0] k_q, k_d, k_s;
  logic [KW-1:0]           k_sat;
  logic                    unused_k;

  // approx_k beyond WIDTH behaves exactly like WIDTH
  assign k_sat    = (approx_k > KW'(WIDTH)) ? KW'(WIDTH) : approx_k;
  assign unused_k = ^k_q[NSTG-1];

  // expand each stage's approx_k into a bit mask
  always_comb begin
    am_s = '0;
    k_d  = k_s;
    for (int s = 0; s < NSTG; s++) begin
      for (int i = 0; i < WIDTH; i++) begin
        am_s[s][i] = (i < int'(k_s[s]));
      end
    end
  end
`else
  assign am_s = '0;
`endif

  // The pipeline moves as one unit whenever the output slot is free or being drained.
  assign in_ready  = !vld_q[NSTG-1] | out_ready;
  assign adv       = in_ready;

  assign out_valid = vld_q[NSTG-1];
  assign sum       = sum_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign g         = gw_q[NSTG-1];
  assign p         = pw_q[NSTG-1];
  assign ovf       = c_q[NSTG-1] ^ cm_q[NSTG-1];

  // Operands are fully consumed by the last stage; its copies are not needed downstream.
  logic unused_ops;
  assign unused_ops = ^{a_q[NSTG-1], b_q[NSTG-1]};

  // route stage inputs: stage 0 from the ports, stage s from register s-1
  always_comb begin
    a_s      = '0;
    b_s      = '0;
    sum_s    = '0;
    vld_s    = '0;
    c_s      = '0;
    gw_s     = '0;
    pw_s     = '0;
    cm_s     = '0;
    a_s[0]   = a;
    b_s[0]   = b;
    vld_s[0] = in_valid;
    c_s[0]   = cin;
    pw_s[0]  = 1'b1;
`ifdef CLA_PIPE_APPROX_EN
    k_s      = '0;
    k_s[0]   = k_sat;
`endif
    for (int s = 1; s < NSTG; s++) begin
      a_s[s]   = a_q[s-1];
      b_s[s]   = b_q[s-1];
      sum_s[s] = sum_q[s-1];
      vld_s[s] = vld_q[s-1];
      c_s[s]   = c_q[s-1];
      gw_s[s]  = gw_q[s-1];
      pw_s[s]  = pw_q[s-1];
      cm_s[s]  = cm_q[s-1];
`ifdef CLA_PIPE_APPROX_EN
      k_s[s]   = k_q[s-1];
`endif
    end
  end

  // resolve this stage's groups with 4-bit lookahead and fold them into the word g/p
  always_comb begin
    logic [3:0]       bg, bp, cg, cp, wg, wp, ms;
    logic [4:0]       cc;
    logic             c, gw, pw, cm, grp_g, grp_p;
    logic [WIDTH-1:0] sm;
    bg = '0; bp = '0; cg = '0; cp = '0; wg = '0; wp = '0; ms = '0; cc = '0;
    c = 1'b0; gw = 1'b0; pw = 1'b0; cm = 1'b0; grp_g = 1'b0; grp_p = 1'b0; sm = '0;
    a_d = '0; b_d = '0; sum_d = '0; vld_d = '0; c_d = '0; gw_d = '0; pw_d = '0; cm_d = '0;
    for (int s = 0; s < NSTG; s++) begin
      sm = sum_s[s];
      c  = c_s[s];
      gw = gw_s[s];
      pw = pw_s[s];
      cm = cm_s[s];
      for (int j = 0; j < GPS; j++) begin
        for (int i = 0; i < 4; i++) begin
          ms[i] = am_s[s][(s*GPS+j)*4+i];
          bg[i] = a_s[s][(s*GPS+j)*4+i] & b_s[s][(s*GPS+j)*4+i];
          bp[i] = a_s[s][(s*GPS+j)*4+i] ^ b_s[s][(s*GPS+j)*4+i];
        end
        // Approximated bits kill the carry chain but are transparent to word g/p.
        cg = bg & ~ms;
        cp = bp & ~ms;
        wg = cg;
        wp = bp | ms;
        cc[0] = c;
        cc[1] = cg[0] | (cp[0] & cc[0]);
        cc[2] = cg[1] | (cp[1] & cg[0]) | (cp[1] & cp[0] & cc[0]);
        cc[3] = cg[2] | (cp[2] & cg[1]) | (cp[2] & cp[1] & cg[0]) | (cp[2] & cp[1] & cp[0] & cc[0]);
        cc[4] = cg[3] | (cp[3] & cg[2]) | (cp[3] & cp[2] & cg[1]) | (cp[3] & cp[2] & cp[1] & cg[0])
              | ((&cp) & cc[0]);
        grp_g = wg[3] | (wp[3] & wg[2]) | (wp[3] & wp[2] & wg[1]) | (wp[3] & wp[2] & wp[1] & wg[0]);
        grp_p = &wp;
        for (int i = 0; i < 4; i++) begin
          sm[(s*GPS+j)*4+i] = ms[i] ? (a_s[s][(s*GPS+j)*4+i] | b_s[s][(s*GPS+j)*4+i])
                                    : (bp[i] ^ cc[i]);
        end
        gw = grp_g | (grp_p & gw);
        pw = grp_p & pw;
        // carry into the MSB is needed later for signed overflow
        if (s*GPS+j == NGRP-1) cm = cc[3];
        c = cc[4];
      end
      a_d[s]   = a_s[s];
      b_d[s]   = b_s[s];
      sum_d[s] = sm;
      vld_d[s] = vld_s[s];
      c_d[s]   = c;
      gw_d[s]  = gw;
      pw_d[s]  = pw;
      cm_d[s]  = cm;
    end
  end

  // advance every stage together; hold everything while the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      vld_q <= '0;
      c_q   <= '0;
      gw_q  <= '0;
      pw_q  <= '0;
      cm_q  <= '0;
`ifdef CLA_PIPE_APPROX_EN
      k_q   <= '0;
`endif
    end else if (adv) begin
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      vld_q <= vld_d;
      c_q   <= c_d;
      gw_q  <= gw_d;
      pw_q  <= pw_d;
      cm_q  <= cm_d;
`ifdef CLA_PIPE_APPROX_EN
      k_q   <= k_d;
`endif
    end
  end

endmodule
